// File: rtl/fft_bars_display.sv
// Spectrum bar renderer: frame-gated bin display bank, per-bin peak hold with
// timed decay, 2-stage pixel pipeline and prescaled value-request pulse.
module fft_bars_display #(
    parameter int unsigned NUM_BINS    = 8,
    parameter int unsigned VAL_W       = 12,
    parameter int unsigned SCREEN_W    = 800,
    parameter int unsigned SCREEN_H    = 600,
    parameter int unsigned POS_W       = 10,
    parameter int unsigned PRE_W       = 16,
    parameter int unsigned GAP         = 4,
    parameter int unsigned DECAY_STEP  = 16,
    parameter int unsigned HOLD_FRAMES = 30
) (
    input  logic                      vga_clk,
    input  logic                      rst_n,
    input  logic [NUM_BINS*VAL_W-1:0] bins_in,
    input  logic                      bins_valid,
    input  logic                      sample_tick,
    input  logic [PRE_W-1:0]          prescaler_in,
    input  logic                      frame_start,
    input  logic [POS_W-1:0]          posx,
    input  logic [POS_W-1:0]          posy,
    output logic                      set_values_flag,
    output logic [3:0]                bin_index,
    output logic [VAL_W-1:0]          val_out,
    output logic                      bar_on,
    output logic                      peak_on
);

    localparam int unsigned BW     = SCREEN_W / NUM_BINS;
    localparam int unsigned USED_W = NUM_BINS * BW;
    localparam int unsigned COL_W  = BW - GAP;
    localparam int unsigned PROD_W = VAL_W + POS_W;
    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

    logic [PRE_W-1:0]  pre_cnt;
    logic [VAL_W-1:0]  shadow    [NUM_BINS];
    logic [VAL_W-1:0]  display   [NUM_BINS];
    logic [VAL_W-1:0]  peak      [NUM_BINS];
    logic [VAL_W-1:0]  peak_nxt  [NUM_BINS];
    logic [VAL_W-1:0]  decayed   [NUM_BINS];
    logic [HOLD_W-1:0] hold      [NUM_BINS];
    logic [HOLD_W-1:0] hold_nxt  [NUM_BINS];

    logic [3:0]        k_c;
    logic [POS_W-1:0]  off_c;
    logic              vis_c;
    logic [VAL_W-1:0]  val_c;
    logic [VAL_W-1:0]  pk_c;

    logic              s1_vis;
    logic [3:0]        s1_k;
    logic [POS_W-1:0]  s1_off;
    logic [POS_W-1:0]  s1_y;
    logic [VAL_W-1:0]  s1_val;
    logic [VAL_W-1:0]  s1_pk;

    logic [POS_W-1:0]  h_c;
    logic [POS_W-1:0]  ph_c;
    logic              col_ok_c;
    logic              bar_c;
    logic              peak_on_c;

    // Sample prescaler: one-cycle request pulse every prescaler_in+1 ticks
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt         <= '0;
            set_values_flag <= 1'b0;
        end else if (sample_tick) begin
            if (pre_cnt == prescaler_in) begin
                pre_cnt         <= '0;
                set_values_flag <= 1'b1;
            end else begin
                pre_cnt         <= pre_cnt + PRE_W'(1);
                set_values_flag <= 1'b0;
            end
        end else begin
            set_values_flag <= 1'b0;
        end
    end

    // Next peak/hold state, using the shadow value that is about to be swapped in
    always_comb begin
        for (int k = 0; k < NUM_BINS; k++) begin
            decayed[k]  = (32'(peak[k]) > DECAY_STEP) ? peak[k] - VAL_W'(DECAY_STEP) : '0;
            peak_nxt[k] = peak[k];
            hold_nxt[k] = hold[k];
            if (shadow[k] >= peak[k]) begin
                peak_nxt[k] = shadow[k];
                hold_nxt[k] = HOLD_W'(HOLD_FRAMES);
            end else if (hold[k] != '0) begin
                hold_nxt[k] = hold[k] - HOLD_W'(1);
            end else begin
                peak_nxt[k] = (decayed[k] > shadow[k]) ? decayed[k] : shadow[k];
            end
        end
    end

    // Shadow capture and frame-boundary swap into display/peak banks
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_BINS; k++) begin
                shadow[k]  <= '0;
                display[k] <= '0;
                peak[k]    <= '0;
                hold[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_BINS; k++) begin
                if (bins_valid) begin
                    shadow[k] <= bins_in[k*VAL_W +: VAL_W];
                end
                if (frame_start) begin
                    display[k] <= shadow[k];
                    peak[k]    <= peak_nxt[k];
                    hold[k]    <= hold_nxt[k];
                end
            end
        end
    end

    // Stage 1 decode: comparator chain for the bin, column offset and bank lookup
    always_comb begin
        k_c   = '0;
        val_c = '0;
        pk_c  = '0;
        for (int j = 1; j < NUM_BINS; j++) begin
            if (32'(posx) >= j * BW) begin
                k_c = 4'(j);
            end
        end
        off_c = POS_W'(32'(posx) - 32'(k_c) * BW);
        vis_c = (32'(posx) < USED_W) && (32'(posy) < SCREEN_H);
        for (int k = 0; k < NUM_BINS; k++) begin
            if (k_c == 4'(k)) begin
                val_c = display[k];
                pk_c  = peak[k];
            end
        end
    end

    // Stage 1 register; bank values are sampled here so a same-cycle swap is not seen
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vis <= 1'b0;
            s1_k   <= '0;
            s1_off <= '0;
            s1_y   <= '0;
            s1_val <= '0;
            s1_pk  <= '0;
        end else begin
            s1_vis <= vis_c;
            s1_k   <= k_c;
            s1_off <= off_c;
            s1_y   <= posy;
            s1_val <= val_c;
            s1_pk  <= pk_c;
        end
    end

    // Stage 2: scale values to screen heights and test the row and column
    always_comb begin
        h_c       = POS_W'((PROD_W'(s1_val) * PROD_W'(SCREEN_H)) >> VAL_W);
        ph_c      = POS_W'((PROD_W'(s1_pk) * PROD_W'(SCREEN_H)) >> VAL_W);
        col_ok_c  = s1_vis && (32'(s1_off) < COL_W);
        bar_c     = col_ok_c && (32'(s1_y) >= SCREEN_H - 32'(h_c));
        peak_on_c = col_ok_c && (ph_c != '0) && (32'(s1_y) == SCREEN_H - 1 - 32'(ph_c));
    end

    // Stage 2 register: pixel outputs, forced to zero off-screen
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_index <= '0;
            val_out   <= '0;
            bar_on    <= 1'b0;
            peak_on   <= 1'b0;
        end else begin
            bin_index <= s1_vis ? s1_k : 4'(0);
            val_out   <= s1_vis ? s1_val : '0;
            bar_on    <= bar_c;
            peak_on   <= peak_on_c;
        end
    end

endmodule

// File: tb/tb_fft_bars_display.sv
// Directed bench for fft_bars_display with a scoreboard of expected pixel outputs.
module tb_fft_bars_display;

    localparam int NB = 8;
    localparam int VW = 12;

    logic            vga_clk = 1'b0;
    logic            rst_n;
    logic [NB*VW-1:0] bins_in;
    logic            bins_valid;
    logic            sample_tick;
    logic [15:0]     prescaler_in;
    logic            frame_start;
    logic [9:0]      posx;
    logic [9:0]      posy;
    logic            set_values_flag;
    logic [3:0]      bin_index;
    logic [VW-1:0]   val_out;
    logic            bar_on;
    logic            peak_on;

    typedef struct {
        string      tag;
        logic [3:0] bin;
        logic [11:0] val;
        logic       bar;
        logic       pk;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   disp_m[NB];
    int   shad_m[NB];
    int   peak_m[NB];
    int   hold_m[NB];
    bit   req = 0;
    bit   d1 = 0;
    bit   d2 = 0;

    fft_bars_display dut (
        .vga_clk        (vga_clk),
        .rst_n          (rst_n),
        .bins_in        (bins_in),
        .bins_valid     (bins_valid),
        .sample_tick    (sample_tick),
        .prescaler_in   (prescaler_in),
        .frame_start    (frame_start),
        .posx           (posx),
        .posy           (posy),
        .set_values_flag(set_values_flag),
        .bin_index      (bin_index),
        .val_out        (val_out),
        .bar_on         (bar_on),
        .peak_on        (peak_on)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=output expected=none");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_bin"},  32'(bin_index), 32'(e.bin));
            chk({e.tag, "_val"},  32'(val_out),   32'(e.val));
            chk({e.tag, "_bar"},  32'(bar_on),    32'(e.bar));
            chk({e.tag, "_peak"}, 32'(peak_on),   32'(e.pk));
        end
    endtask

    // One clock; outputs of a pixel driven two cycles ago are checked 1 ns after the edge
    task automatic step();
        @(posedge vga_clk);
        d2  = d1;
        d1  = req;
        req = 0;
        #1;
        if (d2) pop_check();
    endtask

    function automatic exp_t model(input string tag, input int x, input int y);
        exp_t e;
        int k, off, h, ph;
        e.tag = tag;
        e.bin = '0;
        e.val = '0;
        e.bar = 1'b0;
        e.pk  = 1'b0;
        if (x < 800 && y < 600) begin
            k     = x / 100;
            off   = x % 100;
            h     = disp_m[k] * 600 / 4096;
            ph    = peak_m[k] * 600 / 4096;
            e.bin = 4'(k);
            e.val = 12'(disp_m[k]);
            e.bar = (y >= 600 - h) && (off < 96);
            e.pk  = (ph > 0) && (y == 599 - ph) && (off < 96);
        end
        return e;
    endfunction

    task automatic pix(input string tag, input int x, input int y);
        posx = 10'(x);
        posy = 10'(y);
        req  = 1;
        sb.push_back(model(tag, x, y));
        step();
    endtask

    task automatic drain();
        step();
        step();
    endtask

    function automatic logic [NB*VW-1:0] fill(input int v);
        logic [NB*VW-1:0] r;
        for (int k = 0; k < NB; k++) r[k*VW +: VW] = 12'(v);
        return r;
    endfunction

    function automatic void model_frame();
        int d;
        for (int k = 0; k < NB; k++) begin
            if (shad_m[k] >= peak_m[k]) begin
                peak_m[k] = shad_m[k];
                hold_m[k] = 30;
            end else if (hold_m[k] > 0) begin
                hold_m[k]--;
            end else begin
                d = peak_m[k] - 16;
                if (d < 0) d = 0;
                peak_m[k] = (d > shad_m[k]) ? d : shad_m[k];
            end
            disp_m[k] = shad_m[k];
        end
    endfunction

    task automatic load(input int v);
        bins_in    = fill(v);
        bins_valid = 1'b1;
        step();
        bins_valid = 1'b0;
        for (int k = 0; k < NB; k++) shad_m[k] = v;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        model_frame();
    endtask

    task automatic frame_load(input int v);
        bins_in     = fill(v);
        bins_valid  = 1'b1;
        frame_start = 1'b1;
        step();
        bins_valid  = 1'b0;
        frame_start = 1'b0;
        model_frame();
        for (int k = 0; k < NB; k++) shad_m[k] = v;
    endtask

    initial begin
        int ph;
        for (int k = 0; k < NB; k++) begin
            disp_m[k] = 0;
            shad_m[k] = 0;
            peak_m[k] = 0;
            hold_m[k] = 0;
        end
        rst_n        = 1'b0;
        bins_in      = '0;
        bins_valid   = 1'b0;
        sample_tick  = 1'b0;
        prescaler_in = 16'd3;
        frame_start  = 1'b0;
        posx         = '0;
        posy         = '0;
        repeat (3) @(posedge vga_clk);
        #1;
        chk("rst_flag", 32'(set_values_flag), 0);
        chk("rst_bin",  32'(bin_index), 0);
        chk("rst_val",  32'(val_out), 0);
        chk("rst_bar",  32'(bar_on), 0);
        chk("rst_peak", 32'(peak_on), 0);
        rst_n = 1'b1;

        // Prescaler 3 with a tick every cycle: pulse on ticks 4, 8, 12, 16
        sample_tick = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("flag_tick%0d", i), 32'(set_values_flag), 32'(i % 4 == 0));
        end
        // Reset mid-pulse: outputs drop at once and counting restarts
        rst_n = 1'b0;
        #1;
        chk("midrst_flag", 32'(set_values_flag), 0);
        chk("midrst_bar",  32'(bar_on), 0);
        @(posedge vga_clk);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("flag_after_rst_tick%0d", i), 32'(set_values_flag), 32'(i % 4 == 0));
        end
        sample_tick = 1'b0;
        prescaler_in = 16'd0;
        sample_tick = 1'b1;
        step();
        chk("flag_pre0_a", 32'(set_values_flag), 1);
        step();
        chk("flag_pre0_b", 32'(set_values_flag), 1);
        sample_tick = 1'b0;
        step();
        chk("flag_notick", 32'(set_values_flag), 0);

        // Shadow loaded but not yet swapped
        load(2048);
        pix("nofs_150_300", 150, 300);
        pix("nofs_50_599", 50, 599);
        drain();

        // Frame swap, gap columns and off-screen pixels
        frame();
        pix("b1_300", 150, 300);
        pix("b1_299", 150, 299);
        for (int x = 96; x <= 99; x++) pix($sformatf("gap_%0d", x), x, 300);
        pix("edge_100", 100, 300);
        pix("off_x805", 805, 300);
        pix("off_y600", 150, 600);
        pix("last_799", 799, 599);
        pix("b7_700", 700, 450);
        drain();

        // Scale extremes
        load(4095);
        frame();
        pix("full_row1", 50, 1);
        pix("full_row0", 50, 0);
        pix("full_b3", 350, 599);
        drain();
        load(6);
        frame();
        pix("tiny_599", 50, 599);
        pix("tiny_peak0", 50, 0);
        drain();

        // Coincident bins_valid and frame_start
        load(500);
        frame_load(1000);
        pix("coinc_old", 250, 599);
        drain();
        frame();
        pix("coinc_new", 250, 599);
        drain();

        // Peak hold then decay to zero
        load(4095);
        frame();
        load(0);
        for (int f = 1; f <= 290; f++) begin
            frame();
            if (f == 1 || f == 15 || f == 30 || f == 31 || f == 32 || f == 100 ||
                f == 285 || f == 286 || f == 290) begin
                ph = peak_m[0] * 600 / 4096;
                pix($sformatf("pk_f%0d_row0", f), 50, 0);
                pix($sformatf("pk_f%0d_mark", f), 50, 599 - ph);
                drain();
            end
        end

        drain();
        chk("scoreboard_left", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_bars_display.md
Name: fft_bars_display

Overview:
Parametrised N-bin spectrum bar renderer for the VGA path. It buffers per-bin energy values from the band power calculator and swaps them into the display bank only at frame boundaries, so the picture does not tear. It tracks a per-bin peak-hold marker with timed decay and produces pixel-level bar and peak enables for the colour mux. It also generates the periodic set_values_flag request, driven by a runtime-programmable sample prescaler.

Parameters:
NUM_BINS, 8, number of frequency bars (1..16)
VAL_W, 12, width of each bin energy value
SCREEN_W, 800, visible width in pixels
SCREEN_H, 600, visible height in lines
POS_W, 10, width of posx/posy
PRE_W, 16, prescaler width
GAP, 4, blank columns at the right edge of each bar
DECAY_STEP, 16, peak decrement per frame once hold has expired
HOLD_FRAMES, 30, frames a new peak is held before it starts to decay

Ports:
vga_clk  in  1  pixel clock; the only clock
rst_n  in  1  asynchronous active-low reset
bins_in  in  NUM_BINS*VAL_W  packed bin values; bin k occupies bits [k*VAL_W +: VAL_W]
bins_valid  in  1  one-cycle strobe: capture bins_in into the shadow bank
sample_tick  in  1  one-cycle enable, once per audio sample
prescaler_in  in  PRE_W  number of samples between update requests, minus 1
frame_start  in  1  one-cycle strobe at the start of vertical blank
posx  in  POS_W  current pixel column
posy  in  POS_W  current pixel row
set_values_flag  out  1  one-cycle pulse that requests new band values
bin_index  out  4  bin under the current pixel (pipelined)
val_out  out  VAL_W  display value of that bin (pipelined)
bar_on  out  1  pixel lies inside a bar
peak_on  out  1  pixel lies on a peak marker

Behaviour:
- Reset (async, rst_n=0):
  - shadow bank, display bank, peak registers, hold counters and prescale counter all cleared to 0.
  - All outputs are 0.
- Prescaler:
  - Counter advances only on sample_tick.
  - On sample_tick with counter==prescaler_in: set_values_flag=1 for exactly one cycle and the counter returns to 0.
  - On any other sample_tick: counter+1 and flag=0.
  - prescaler_in=0 gives a flag on every tick.
  - If prescaler_in is lowered below the current count, the counter wraps through 2^PRE_W. This is accepted behaviour.
- Shadow bank: on bins_valid, all NUM_BINS values are captured in that cycle.
- Frame swap:
  - On frame_start, display[k] <= shadow[k] for every k.
  - If bins_valid and frame_start coincide, the display takes the old shadow contents and the shadow takes the new data. The new data appears on the following frame.
- Peak logic: evaluated on frame_start, using the value being swapped in as v.
  - If v >= peak[k]: peak[k]=v and hold[k]=HOLD_FRAMES.
  - Else if hold[k]>0: hold[k]-1.
  - Else: peak[k]=max(peak[k]-DECAY_STEP, v). The subtraction saturates at 0.
- Bin width: BW=SCREEN_W/NUM_BINS (integer division). Columns at or beyond NUM_BINS*BW are blank.
- Pixel pipeline, latency 2 cycles:
  - The outputs at cycle t+2 correspond to posx/posy sampled at cycle t.
  - Stage 1: compute the bin index k=posx/BW (a comparator chain is allowed, no divider IP) and the column offset within the bar.
  - Stage 2: compute the scaled heights and the row test.
- Scaling:
  - h=(display[k]*SCREEN_H)>>VAL_W and ph=(peak[k]*SCREEN_H)>>VAL_W.
  - Full-precision product, VAL_W+POS_W bits.
- Pixel outputs:
  - bar_on=1 when posy >= SCREEN_H-h, and the column offset < BW-GAP, and the pixel is in the visible area.
  - peak_on=1 when ph>0, posy==SCREEN_H-1-ph, and the column test passes.
  - bar_on and peak_on may both be 1 on the same pixel.
- Off-screen pixels (posx>=SCREEN_W, posy>=SCREEN_H, or the blank remainder columns): bin_index=0, val_out=0, bar_on=0, peak_on=0.
- Timing of a swap: a swap in the same cycle as a pixel sample affects pixels sampled on or after the following cycle. frame_start only occurs during blanking, so no visible pixel is affected.

Test Plan:
- Reset and prescaler: reset, prescaler_in=3, continuous sample_tick -> set_values_flag pulses on ticks 4, 8, 12, each exactly 1 cycle wide. Assert rst_n low mid-count -> all outputs 0 immediately and counting restarts from 0.
- Frame-gated update: load bins all 2048 via bins_valid, with no frame_start -> bar_on=0 everywhere. After frame_start, at posx=150 (bin 1), posy=300 -> two cycles later bin_index=1, val_out=2048, bar_on=1. At posy=299 -> bar_on=0.
- Gap and blank area: posx=96..99 -> bar_on=0 (GAP). posx=100 -> bin_index=1. posx=805 or posy=600 -> all outputs 0.
- Peak hold and decay: bin 0 set to 4095 then 0 -> peak marker held at row 0 for 30 frames, then peak decreases by 16 per frame, reaching 0 after 256 decay frames. Then peak_on=0.
- Simultaneous strobes: bins_valid (value 1000) together with frame_start, shadow previously 500 -> display=500 for that frame and 1000 on the next frame.
- Scale extremes: value 4095 -> h=599, rows 1..599 lit. Value 6 -> h=0, no bar.
